// File: rtl/alu_pkg.sv
// Shared ALU encodings: operation select values
// and bit positions of the result flag vector.
package alu_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int FLAG_COUT = 0;
  localparam int FLAG_OVF  = 1;
  localparam int FLAG_ZERO = 2;
  localparam int FLAG_NEG  = 3;
  localparam int NFLAGS    = 4;

endpackage

// File: rtl/cla_chunk.sv
// N-bit two-level carry-lookahead adder chunk.
// a/b/cin in; sum, cout, c_msb_in (carry into MSB) out.
module cla_chunk #(
  parameter int N = 16
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         c_msb_in
);

  localparam int NG = N / 4;

  logic [N-1:0]  g;
  logic [N-1:0]  p;
  logic [N-1:0]  c;
  logic [NG-1:0] gg;
  logic [NG-1:0] pg;
  logic [NG:0]   cg;

  always_comb begin
    g  = a & b;
    p  = a ^ b;
    c  = '0;
    gg = '0;
    pg = '0;
    cg = '0;
    cg[0] = cin;
    // Upper level: group carries from group generate/propagate.
    for (int j = 0; j < NG; j++) begin
      gg[j] = g[4*j+3]
            | (p[4*j+3] & (g[4*j+2]
            | (p[4*j+2] & (g[4*j+1]
            | (p[4*j+1] & g[4*j])))));
      pg[j] = &p[4*j +: 4];
      cg[j+1] = gg[j] | (pg[j] & cg[j]);
    end
    // Lower level: bit carries inside each group.
    for (int j = 0; j < NG; j++) begin
      c[4*j] = cg[j];
      for (int i = 1; i < 4; i++) begin
        c[4*j+i] = g[4*j+i-1]
                 | (p[4*j+i-1] & c[4*j+i-1]);
      end
    end
  end

  assign sum      = p ^ c;
  assign cout     = cg[NG];
  assign c_msb_in = c[N-1];

endmodule

// File: rtl/pipe_cla_addsub.sv
// Pipelined CLA add/sub, one operand chunk per stage.
// in_* valid/ready beat in; out_* result + flags.
module pipe_cla_addsub
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero,
  output logic             out_neg
);

  localparam int CW = WIDTH / STAGES;

  logic              advance;
  logic              valid_q;
  logic [WIDTH-1:0]  sum_q;
  logic [NFLAGS-1:0] flag_q;

  assign advance  = !valid_q | out_ready;
  assign in_ready = advance;

  // Operand A rotates: each stage pushes its sum
  // chunk in at the top and drops the consumed
  // chunk, so after the last stage it is the sum.
  // B shrinks by one chunk per stage.
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int BW = WIDTH - k * CW;

    logic [WIDTH-1:0] ai;
    logic [WIDTH-1:0] ao;
    logic [BW-1:0]    bi;
    logic             ci;
    logic             vi;
    logic [CW-1:0]    s;
    logic             co;

    if (k == 0) begin : g_in
      assign ai = in_a;
      assign bi = (in_op == OP_SUB) ? ~in_b : in_b;
      assign ci = (in_op == OP_SUB);
      assign vi = in_valid;
    end else begin : g_reg
      logic [WIDTH-1:0] a_q;
      logic [BW-1:0]    b_q;
      logic             c_q;
      logic             v_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v_q <= 1'b0;
        end else if (advance) begin
          v_q <= g_st[k-1].vi;
        end
      end

      always_ff @(posedge clk) begin
        if (advance) begin
          a_q <= g_st[k-1].ao;
          b_q <= g_st[k-1].bi[BW+CW-1:CW];
          c_q <= g_st[k-1].co;
        end
      end

      assign ai = a_q;
      assign bi = b_q;
      assign ci = c_q;
      assign vi = v_q;
    end

    if (CW == WIDTH) begin : g_rot1
      assign ao = s;
    end else begin : g_rotn
      assign ao = {s, ai[WIDTH-1:CW]};
    end

    if (k == STAGES - 1) begin : g_last
      logic              cm;
      logic [NFLAGS-1:0] flag_d;

      cla_chunk #(.N(CW)) u_cla (
        .a        (ai[CW-1:0]),
        .b        (bi[CW-1:0]),
        .cin      (ci),
        .sum      (s),
        .cout     (co),
        .c_msb_in (cm)
      );

      always_comb begin
        flag_d            = '0;
        flag_d[FLAG_COUT] = co;
        flag_d[FLAG_OVF]  = co ^ cm;
        flag_d[FLAG_ZERO] = ~|ao;
        flag_d[FLAG_NEG]  = ao[WIDTH-1];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          valid_q <= 1'b0;
          sum_q   <= '0;
          flag_q  <= '0;
        end else if (advance) begin
          valid_q <= vi;
          if (vi) begin
            sum_q  <= ao;
            flag_q <= flag_d;
          end
        end
      end
    end else begin : g_mid
      // Carry into a middle chunk's MSB has no meaning.
      logic c_msb_unused;

      cla_chunk #(.N(CW)) u_cla (
        .a        (ai[CW-1:0]),
        .b        (bi[CW-1:0]),
        .cin      (ci),
        .sum      (s),
        .cout     (co),
        .c_msb_in (c_msb_unused)
      );
    end
  end

  assign out_valid = valid_q;
  assign out_sum   = sum_q;
  assign out_cout  = flag_q[FLAG_COUT];
  assign out_ovf   = flag_q[FLAG_OVF];
  assign out_zero  = flag_q[FLAG_ZERO];
  assign out_neg   = flag_q[FLAG_NEG];

endmodule

// File: tb/tb_pipe_cla_addsub.sv
// Directed + stream bench for pipe_cla_addsub:
// 32-bit/2-stage and 64-bit/4-stage instances.
module tb_pipe_cla_addsub;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, in_op;
  logic [31:0] in_a, in_b;
  logic        out_valid, out_ready;
  logic [31:0] out_sum;
  logic        out_cout, out_ovf, out_zero, out_neg;

  logic        w_in_valid, w_in_ready, w_in_op;
  logic [63:0] w_in_a, w_in_b;
  logic        w_out_valid, w_out_ready;
  logic [63:0] w_out_sum;
  logic        w_out_cout, w_out_ovf, w_out_zero, w_out_neg;

  pipe_cla_addsub #(.WIDTH(32), .STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout),
    .out_ovf(out_ovf), .out_zero(out_zero),
    .out_neg(out_neg)
  );

  pipe_cla_addsub #(.WIDTH(64), .STAGES(4)) dut64 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(w_in_valid), .in_ready(w_in_ready),
    .in_a(w_in_a), .in_b(w_in_b), .in_op(w_in_op),
    .out_valid(w_out_valid), .out_ready(w_out_ready),
    .out_sum(w_out_sum), .out_cout(w_out_cout),
    .out_ovf(w_out_ovf), .out_zero(w_out_zero),
    .out_neg(w_out_neg)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm,
                     input logic [67:0] act,
                     input logic [67:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
    logic        neg;
  } vec_t;

  vec_t vecs[10];

  function automatic logic [35:0] ref_model(
    input logic op, input logic [31:0] a,
    input logic [31:0] b);
    logic [31:0] bb;
    logic [32:0] r;
    logic        ov;
    bb = op ? ~b : b;
    r  = {1'b0, a} + {1'b0, bb} + {32'd0, op};
    ov = (a[31] == bb[31]) && (r[31] != a[31]);
    return {r[31], (r[31:0] == 32'd0), ov, r[32], r[31:0]};
  endfunction

  function automatic logic [35:0] out_pack();
    return {out_neg, out_zero, out_ovf, out_cout, out_sum};
  endfunction

  task automatic apply_vec(input string nm, input vec_t v);
    @(negedge clk);
    in_valid = 1'b1;
    in_op = v.op;
    in_a = v.a;
    in_b = v.b;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk({nm, "_early"}, out_valid, 1'b0);
    @(negedge clk);
    #1;
    chk({nm, "_valid"}, out_valid, 1'b1);
    chk({nm, "_res"}, out_pack(),
        {v.neg, v.zero, v.ovf, v.cout, v.sum});
  endtask

  task automatic apply64(input string nm, input logic op,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] s, input logic [3:0] fl);
    int early;
    early = 0;
    @(negedge clk);
    w_in_valid = 1'b1;
    w_in_op = op;
    w_in_a = a;
    w_in_b = b;
    @(negedge clk);
    w_in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      if (w_out_valid) early++;
    end
    @(negedge clk);
    #1;
    chk({nm, "_early"}, early, 0);
    chk({nm, "_valid"}, w_out_valid, 1'b1);
    chk({nm, "_res"},
        {w_out_neg, w_out_zero, w_out_ovf, w_out_cout, w_out_sum},
        {fl, s});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [35:0] exp_q[$];
    logic [35:0] held;
    logic [35:0] e;
    logic        stalled_prev;
    logic        acc, dl, pending;
    int          sent, got, stale;
    vec_t        v;

    vecs[0] = '{1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 32'h0000FFFF, 32'h00000001, 32'h00010000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 32'h00000007, 32'h00000007, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 32'h12345678, 32'h9ABCDEF0, 32'hACF13568, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{1'b0, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[8] = '{1'b1, 32'h00000000, 32'h00000000, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[9] = '{1'b1, 32'h00010000, 32'h00000001, 32'h0000FFFF, 1'b1, 1'b0, 1'b0, 1'b0};

    in_valid = 1'b0; in_op = 1'b0; in_a = '0; in_b = '0;
    out_ready = 1'b1;
    w_in_valid = 1'b0; w_in_op = 1'b0; w_in_a = '0; w_in_b = '0;
    w_out_ready = 1'b1;

    // Reset state
    #12;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_res", out_pack(), 36'd0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_w_out_valid", w_out_valid, 1'b0);
    chk("rst_w_in_ready", w_in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", in_ready, 1'b1);

    // Directed table
    for (int i = 0; i < 10; i++) begin
      apply_vec($sformatf("vec%0d", i), vecs[i]);
    end

    // Stream with a 3-cycle output stall
    sent = 0; got = 0; stalled_prev = 1'b0; pending = 1'b0;
    held = '0;
    for (int n = 0; n < 80 && got < 10; n++) begin
      @(negedge clk);
      out_ready = !(n >= 4 && n < 7);
      if (!pending && sent < 10) begin
        in_valid = 1'b1;
        in_a = $urandom;
        in_b = $urandom;
        in_op = 1'($urandom_range(0, 1));
        pending = 1'b1;
      end else if (!pending) begin
        in_valid = 1'b0;
      end
      #1;
      if (stalled_prev) chk("stall_hold", out_pack(), held);
      if (out_valid && !out_ready) begin
        chk("stall_in_ready", in_ready, 1'b0);
        held = out_pack();
        stalled_prev = 1'b1;
      end else begin
        stalled_prev = 1'b0;
      end
      acc = in_valid && in_ready;
      dl = out_valid && out_ready;
      if (dl) begin
        if (exp_q.size() == 0) begin
          chk("stream_extra", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("stream%0d", got), out_pack(), e);
          got++;
        end
      end
      if (acc) begin
        exp_q.push_back(ref_model(in_op, in_a, in_b));
        sent++;
        pending = 1'b0;
      end
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("stream_count", got, 10);

    // Reset with two beats in flight
    @(negedge clk);
    in_valid = 1'b1; in_op = 1'b0; in_a = 32'd1; in_b = 32'd2;
    @(negedge clk);
    in_a = 32'd3; in_b = 32'd4;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("inflight_valid", out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_res", out_pack(), 36'd0);
    chk("mid_rst_in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      if (out_valid) stale++;
    end
    chk("no_stale", stale, 0);
    v = '{1'b0, 32'd10, 32'd20, 32'd30, 1'b0, 1'b0, 1'b0, 1'b0};
    apply_vec("post_rst", v);

    // 64-bit, 4 stages: carry through every chunk
    apply64("w64_ripple", 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,
            64'd0, 4'b0101);
    apply64("w64_sub", 1'b1, 64'd0, 64'd1,
            64'hFFFF_FFFF_FFFF_FFFF, 4'b1000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
